// File: rtl/display_scan_if.sv
// -----------------------------------------------------------------------------
// display_scan_if
// Producer-to-display handshake bundle for display_scan_controller.
//   value : packed hex digits, digit 0 (leftmost) in the top nibble
//   load  : value valid, driven by the producer
//   ready : shadow register free, driven by the display controller
// Modports: master = value producer, slave = display controller.
// -----------------------------------------------------------------------------
interface display_scan_if #(
    parameter int NDIG = 2
);
    logic [4*NDIG-1:0] value;
    logic              load;
    logic              ready;

    modport master (output value, output load, input ready);
    modport slave  (input value, input load, output ready);
endinterface

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
// Time-multiplexed scan of a common-cathode multi-digit seven-segment display.
// Each digit slot is a blanked dead-time interval followed by the lit interval;
// new values land in a shadow register and are committed to the displayed
// value only at the frame boundary (end of the last digit's lit interval).
//
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high
//   bus      : display_scan_if.slave (value / load / ready handshake)
//   led_port : segments {g,f,e,d,c,b,a}, active-high
//   digit_en : one-hot digit select, bit i = digit i
//   c        : high while the scan index is 0 (left digit cathode select)
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (the rightmost digit is always decoded).
// -----------------------------------------------------------------------------
module display_scan_controller #(
    parameter int NDIG            = 2,
    parameter int TICKS_PER_DIGIT = 60000,
    parameter int DEAD_CYCLES     = 600
) (
    input  logic              clk,
    input  logic              reset,
    display_scan_if.slave     bus,
    output logic [6:0]        led_port,
    output logic [NDIG-1:0]   digit_en,
    output logic              c
);

    localparam int CNT_BIG = (TICKS_PER_DIGIT > DEAD_CYCLES) ? TICKS_PER_DIGIT : DEAD_CYCLES;
    localparam int CNT_MAX = (CNT_BIG > 1) ? CNT_BIG : 1;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NDIG - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // With no dead time the scan never visits BLANK, so it also starts in SHOW.
    localparam state_t ST_START = (DEAD_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [4*NDIG-1:0]   active, active_d;
    logic [4*NDIG-1:0]   shadow;
    logic                pending, pending_d;
    logic                ready_r;
    logic                frame_end;
    logic                accept;
    logic                commit;
    logic [3:0]          digit_d;
    logic [6:0]          led_d;
    logic [NDIG-1:0]     en_d;
    logic                c_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic [4*NDIG-1:0]   upper_d;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign bus.ready = ready_r;

    // Next-state, handshake and output decode. Outputs are computed from the
    // next state so the output registers always agree with the state register.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt + 1'b1;
        frame_end = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == DEAD_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == TICK_LAST) begin
                    cnt_d   = '0;
                    state_d = (DEAD_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    if (idx == IDX_LAST) begin
                        idx_d     = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_START;
                cnt_d   = '0;
            end
        endcase

        // accept and commit are mutually exclusive: one needs pending low,
        // the other pending high. A load taken on the boundary edge therefore
        // waits for the following boundary.
        accept    = bus.load & ready_r;
        commit    = frame_end & pending;
        active_d  = commit ? shadow : active;
        pending_d = accept ? 1'b1 : (commit ? 1'b0 : pending);

        digit_d = 4'(active_d >> (4 * (NDIG - 1 - int'(idx_d))));
        c_d     = (idx_d == '0);
        en_d    = '0;
        led_d   = '0;
`ifdef LEADING_ZERO_BLANK_EN
        // Digits 0..idx of the value, right-aligned; all zero means this digit
        // is a leading zero.
        upper_d = active_d >> (4 * (NDIG - 1 - int'(idx_d)));
`endif
        if (state_d == ST_SHOW) begin
            en_d  = NDIG'(1) << idx_d;
            led_d = seg_decode(digit_d);
`ifdef LEADING_ZERO_BLANK_EN
            if ((upper_d == '0) && (idx_d != IDX_LAST)) begin
                led_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_START;
            idx      <= '0;
            cnt      <= '0;
            active   <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            ready_r  <= 1'b1;
            led_port <= '0;
            digit_en <= '0;
            c        <= 1'b1;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            active   <= active_d;
            pending  <= pending_d;
            ready_r  <= ~pending_d;
            led_port <= led_d;
            digit_en <= en_d;
            c        <= c_d;
            if (accept) begin
                shadow <= bus.value;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
// Two controllers (dead time 1 and dead time 0, 4 ticks per digit, 2 digits)
// compared every cycle against a frame-position reference model: the expected
// outputs follow from the cycle count since reset, the frame length and the
// committed value, not from any state machine.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

    localparam int NDIG = 2;
    localparam int T    = 4;
    localparam int FR0  = NDIG * (1 + T);
    localparam int FR1  = NDIG * T;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_if #(.NDIG(NDIG)) bus0 ();
    display_scan_if #(.NDIG(NDIG)) bus1 ();

    logic [6:0] led0, led1;
    logic [1:0] en0, en1;
    logic       c0, c1;

    display_scan_controller #(.NDIG(NDIG), .TICKS_PER_DIGIT(T), .DEAD_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .led_port(led0), .digit_en(en0), .c(c0));
    display_scan_controller #(.NDIG(NDIG), .TICKS_PER_DIGIT(T), .DEAD_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .led_port(led1), .digit_en(en1), .c(c1));

    wire [10:0] obs0 = {bus0.ready, c0, en0, led0};
    wire [10:0] obs1 = {bus1.ready, c1, en1, led1};

    int nvec = 0;
    int nerr = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: edges since the last reset edge, committed/shadow value.
    int         m_k       [2];
    logic [7:0] m_active  [2];
    logic [7:0] m_shadow  [2];
    bit         m_pending [2];
    bit         m_acc     [2];
    logic [7:0] txq [$];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_k[i] = 0; m_active[i] = 8'h00; m_shadow[i] = 8'h00;
                m_pending[i] = 1'b0; m_acc[i] = 1'b0;
            end else begin
                m_k[i]++;
                m_acc[i] = ((i == 0) ? bus0.load : bus1.load) && !m_pending[i];
                if ((m_k[i] % ((i == 0) ? FR0 : FR1)) == 0 && m_pending[i]) begin
                    m_active[i]  = m_shadow[i];
                    m_pending[i] = 1'b0;
                end
                if (m_acc[i]) begin
                    m_shadow[i]  = (i == 0) ? bus0.value : bus1.value;
                    m_pending[i] = 1'b1;
                end
            end
        end
    end

    // Expected {ready, c, digit_en, led_port} after the latest edge.
    function automatic logic [10:0] exp_out(input int i);
        int dead = (i == 0) ? 1 : 0;
        int slot = dead + T;
        int p, d, sh;
        logic [6:0] led;
        logic [1:0] en;
        if (m_k[i] == 0) return 11'h600;
        p  = m_k[i] % (NDIG * slot);
        d  = p / slot;
        sh = 4 * (NDIG - 1 - d);
        if ((p % slot) < dead) return {!m_pending[i], (d == 0), 2'b00, 7'h00};
        en  = 2'(1 << d);
        led = seg_tab[int'((m_active[i] >> sh) & 8'h0F)];
`ifdef LEADING_ZERO_BLANK_EN
        if (d != NDIG - 1 && (m_active[i] >> sh) == 8'h00) led = 7'h00;
`endif
        return {!m_pending[i], (d == 0), en, led};
    endfunction

    // Advance one clock; act as the producer for both buses (hold load until taken).
    task automatic step();
        @(posedge clk);
        #1;
        if (m_acc[0]) void'(txq.pop_front());
        if (txq.size() > 0) begin
            bus0.load  = 1'b1;
            bus0.value = txq[0];
        end else begin
            bus0.load  = 1'b0;
            bus0.value = 8'($urandom);
        end
        if (m_acc[1]) bus1.load = 1'b0;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            step();
            nvec++;
            if (obs0 !== 11'h600) begin
                nerr++; $display("FAIL reset_out0 cyc=%0d: got %h expected %h", n, obs0, 11'h600);
            end
            nvec++;
            if (obs1 !== 11'h600) begin
                nerr++; $display("FAIL reset_out1 cyc=%0d: got %h expected %h", n, obs1, 11'h600);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_3a();
        txq.push_back(8'h3A);
        for (int n = 0; n < 3 * FR0; n++) begin
            step();
            nvec++;
            if (obs0 !== exp_out(0)) begin
                nerr++; $display("FAIL scan_3a k=%0d: got %h expected %h", m_k[0], obs0, exp_out(0));
            end
            if (m_active[0] == 8'h3A && (m_k[0] % FR0) == 1) begin
                nvec++;
                if ({c0, en0, led0} !== {1'b1, 2'b01, 7'h4F}) begin
                    nerr++; $display("FAIL scan_3a_left: got %h expected %h", {c0, en0, led0}, {1'b1, 2'b01, 7'h4F});
                end
            end
            if (m_active[0] == 8'h3A && (m_k[0] % FR0) == 6) begin
                nvec++;
                if ({c0, en0, led0} !== {1'b0, 2'b10, 7'h77}) begin
                    nerr++; $display("FAIL scan_3a_right: got %h expected %h", {c0, en0, led0}, {1'b0, 2'b10, 7'h77});
                end
            end
        end
    endtask

    task automatic test_hold_load();
        txq.push_back(8'h12);
        txq.push_back(8'h34);
        for (int n = 0; n < 4 * FR0; n++) begin
            step();
            nvec++;
            if (obs0 !== exp_out(0)) begin
                nerr++; $display("FAIL hold_load k=%0d: got %h expected %h", m_k[0], obs0, exp_out(0));
            end
        end
    endtask

    task automatic test_boundary_load();
        int guard = 0;
        while (!((m_k[0] % FR0) == FR0 - 2 && !m_pending[0] && txq.size() == 0) && guard < 100) begin
            step();
            guard++;
        end
        nvec++;
        if (guard >= 100) begin
            nerr++; $display("FAIL boundary_sync: got timeout after %0d cycles expected alignment", guard);
        end
        txq.push_back(8'h55);
        for (int n = 0; n < 4 * FR0; n++) begin
            step();
            nvec++;
            if (obs0 !== exp_out(0)) begin
                nerr++; $display("FAIL boundary_load k=%0d: got %h expected %h", m_k[0], obs0, exp_out(0));
            end
        end
    endtask

    task automatic test_reset_mid_show();
        int guard = 0;
        txq.push_back(8'($urandom_range(1, 255)));
        while (!(m_pending[0] && (m_k[0] % (FR0 / 2)) == 3) && guard < 100) begin
            step();
            guard++;
        end
        nvec++;
        if (guard >= 100) begin
            nerr++; $display("FAIL midreset_sync: got timeout after %0d cycles expected pending show", guard);
        end
        reset = 1'b1;
        step();
        nvec++;
        if (obs0 !== 11'h600) begin
            nerr++; $display("FAIL midreset_out: got %h expected %h", obs0, 11'h600);
        end
        reset = 1'b0;
        for (int n = 0; n < 2 * FR0; n++) begin
            step();
            nvec++;
            if (obs0 !== exp_out(0)) begin
                nerr++; $display("FAIL midreset_after k=%0d: got %h expected %h", m_k[0], obs0, exp_out(0));
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] vals [2] = '{8'h05, 8'h00};
        logic [6:0] left;
`ifdef LEADING_ZERO_BLANK_EN
        left = 7'h00;
`else
        left = 7'h3F;
`endif
        for (int v = 0; v < 2; v++) begin
            txq.push_back(vals[v]);
            for (int n = 0; n < 3 * FR0; n++) begin
                step();
                nvec++;
                if (obs0 !== exp_out(0)) begin
                    nerr++; $display("FAIL lead_zero k=%0d: got %h expected %h", m_k[0], obs0, exp_out(0));
                end
                if (m_active[0] == vals[v] && !m_pending[0] && (m_k[0] % FR0) == 2) begin
                    nvec++;
                    if (led0 !== left) begin
                        nerr++; $display("FAIL lead_zero_left val=%h: got %h expected %h", vals[v], led0, left);
                    end
                end
            end
        end
    endtask

    task automatic test_dead_zero();
        bus1.value = 8'h88;
        bus1.load  = 1'b1;
        for (int n = 0; n < 4 * FR1; n++) begin
            step();
            nvec++;
            if (obs1 !== exp_out(1)) begin
                nerr++; $display("FAIL dead_zero k=%0d: got %h expected %h", m_k[1], obs1, exp_out(1));
            end
            if (m_active[1] == 8'h88) begin
                nvec++;
                if (led1 !== 7'h7F) begin
                    nerr++; $display("FAIL dead_zero_led k=%0d: got %h expected %h", m_k[1], led1, 7'h7F);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            txq.push_back(8'($urandom));
            for (int n = 0; n < int'($urandom_range(1, 25)); n++) begin
                step();
                nvec++;
                if (obs0 !== exp_out(0)) begin
                    nerr++; $display("FAIL random k=%0d: got %h expected %h", m_k[0], obs0, exp_out(0));
                end
                nvec++;
                if (obs1 !== exp_out(1)) begin
                    nerr++; $display("FAIL random_dz k=%0d: got %h expected %h", m_k[1], obs1, exp_out(1));
                end
            end
        end
        for (int n = 0; n < 60 * FR0 && txq.size() > 0; n++) step();
    endtask

    initial begin
        bus0.load  = 1'b0;
        bus0.value = 8'h00;
        bus1.load  = 1'b0;
        bus1.value = 8'h00;
        test_reset();
        test_scan_3a();
        test_hold_load();
        test_boundary_load();
        test_reset_mid_show();
        test_leading_zero();
        test_dead_zero();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
